rf_operand_fetch: RTL and testbench

Reader-side companion to the 2R1W register file. It accepts decoded instructions (rs1/rs2/rd) over a valid/ready handshake, drives the register file read addresses and tracks in-flight destination writes in a per-register scoreboard. It stalls on RAW/WAW hazards, forwards same-cycle writeback data and presents registered operands to execute over a second valid/ready handshake. It sits between decode and execute; writeback drives the register file write port and this block's wb_* inputs in parallel.

---
 rtl/rf_operand_fetch.sv | 102 ++++++++++
 tb/tb_rf_operand_fetch.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_operand_fetch.sv
// Operand fetch stage: reads the register file, keeps a per-register pending scoreboard,
// stalls on RAW/WAW hazards and forwards same-cycle writeback into registered operands.
module rf_operand_fetch #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] in_rs1,
   input  logic [ADDR_WIDTH-1:0] in_rs2,
   input  logic [ADDR_WIDTH-1:0] in_rd,
   input  logic                  in_rd_wen,
   output logic [ADDR_WIDTH-1:0] rf_raddr1,
   output logic [ADDR_WIDTH-1:0] rf_raddr2,
   input  logic [DATA_WIDTH-1:0] rf_rdata1,
   input  logic [DATA_WIDTH-1:0] rf_rdata2,
   input  logic                  wb_valid,
   input  logic [ADDR_WIDTH-1:0] wb_addr,
   input  logic [DATA_WIDTH-1:0] wb_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_src1,
   output logic [DATA_WIDTH-1:0] out_src2,
   output logic [ADDR_WIDTH-1:0] out_rd,
   output logic                  out_rd_wen,
   output logic                  idle
);

   localparam int NREG = 2 ** ADDR_WIDTH;

   logic [NREG-1:0]       pending;
   logic [NREG-1:0]       pending_next;
   logic                  wb_hit1, wb_hit2, wb_hit_rd;
   logic                  haz1, haz2, haz_rd;
   logic                  accept;
   logic [DATA_WIDTH-1:0] src1, src2;

   assign rf_raddr1 = in_rs1;
   assign rf_raddr2 = in_rs2;

   assign wb_hit1   = wb_valid && (wb_addr == in_rs1) && (in_rs1 != '0);
   assign wb_hit2   = wb_valid && (wb_addr == in_rs2) && (in_rs2 != '0);
   assign wb_hit_rd = wb_valid && (wb_addr == in_rd)  && (in_rd  != '0);

   // A pending register being written back this cycle is no longer a hazard.
   assign haz1   = (in_rs1 != '0) && pending[in_rs1] && !wb_hit1;
   assign haz2   = (in_rs2 != '0) && pending[in_rs2] && !wb_hit2;
   assign haz_rd = in_rd_wen && (in_rd != '0) && pending[in_rd] && !wb_hit_rd;

   assign in_ready = !flush && (!out_valid || out_ready) && !haz1 && !haz2 && !haz_rd;
   assign accept   = in_valid && in_ready;

   assign idle = (pending == '0) && !out_valid;

   always_comb begin
      src1 = rf_rdata1;
      src2 = rf_rdata2;
      if (in_rs1 == '0)  src1 = '0;
      else if (wb_hit1)  src1 = wb_data;
      if (in_rs2 == '0)  src2 = '0;
      else if (wb_hit2)  src2 = wb_data;
   end

   // Clear from writeback first so a same-cycle set on the same register wins.
   always_comb begin
      pending_next = pending;
      if (wb_valid)
         pending_next[wb_addr] = 1'b0;
      if (accept && in_rd_wen)
         pending_next[in_rd] = 1'b1;
      pending_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending    <= '0;
         out_valid  <= 1'b0;
         out_src1   <= '0;
         out_src2   <= '0;
         out_rd     <= '0;
         out_rd_wen <= 1'b0;
      end else if (flush) begin
         pending   <= '0;
         out_valid <= 1'b0;
      end else begin
         pending <= pending_next;
         if (accept) begin
            out_valid  <= 1'b1;
            out_src1   <= src1;
            out_src2   <= src2;
            out_rd     <= in_rd;
            out_rd_wen <= in_rd_wen;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rf_operand_fetch.sv
// Bench for rf_operand_fetch: bench-side register file, scoreboard model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_rf_operand_fetch;

   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [AW-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
   logic          in_rd_wen = 1'b0;
   logic [AW-1:0] rf_raddr1, rf_raddr2;
   logic [DW-1:0] rf_rdata1, rf_rdata2;
   logic          wb_valid = 1'b0;
   logic [AW-1:0] wb_addr = '0;
   logic [DW-1:0] wb_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [DW-1:0] out_src1, out_src2;
   logic [AW-1:0] out_rd;
   logic          out_rd_wen;
   logic          idle;

   int total = 0;
   int bad = 0;
   bit chk_en = 1'b0;

   logic [DW-1:0] regs [32];

   // Model state
   bit   [31:0]   m_pend = '0;
   bit            mv = 1'b0;
   logic [DW-1:0] ms1 = '0, ms2 = '0;
   logic [AW-1:0] mrd = '0;
   logic          mwen = 1'b0;

   rf_operand_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_src1(out_src1), .out_src2(out_src2),
      .out_rd(out_rd), .out_rd_wen(out_rd_wen), .idle(idle)
   );

   always #5 clk = ~clk;

   assign rf_rdata1 = regs[rf_raddr1];
   assign rf_rdata2 = regs[rf_raddr2];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic bit hit(input logic [AW-1:0] r);
      return wb_valid && wb_addr == r && r != 0;
   endfunction

   function automatic bit busy(input logic [AW-1:0] r);
      return r != 0 && m_pend[r] && !hit(r);
   endfunction

   function automatic bit m_ready();
      if (flush) return 1'b0;
      if (mv && !out_ready) return 1'b0;
      if (busy(in_rs1) || busy(in_rs2)) return 1'b0;
      if (in_rd_wen && busy(in_rd)) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [DW-1:0] operand(input logic [AW-1:0] r);
      if (r == 0) return '0;
      if (hit(r)) return wb_data;
      return regs[r];
   endfunction

   // Model plus the bench register file; the write lands on the same edge as the DUT's capture.
   always @(posedge clk) begin
      bit acc;
      if (rst) begin
         m_pend = '0; mv = 1'b0; ms1 = '0; ms2 = '0; mrd = '0; mwen = 1'b0;
         for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + i;
         regs[0] = 32'hDEAD;
         regs[5] = 32'h11;
         regs[6] = 32'h22;
      end else begin
         if (flush) begin
            m_pend = '0;
            mv = 1'b0;
         end else begin
            acc = in_valid && m_ready();
            if (acc) begin
               ms1 = operand(in_rs1); ms2 = operand(in_rs2);
               mrd = in_rd; mwen = in_rd_wen; mv = 1'b1;
            end else if (out_ready) begin
               mv = 1'b0;
            end
            if (wb_valid && wb_addr != 0) m_pend[wb_addr] = 1'b0;
            if (acc && in_rd_wen && in_rd != 0) m_pend[in_rd] = 1'b1;
         end
         if (wb_valid && wb_addr != 0) regs[wb_addr] = wb_data;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("m_in_ready", in_ready, m_ready());
         check("m_idle", idle, (m_pend == 0) && !mv);
         check("m_out_valid", out_valid, mv);
         if (mv) begin
            check("m_out_src1", out_src1, ms1);
            check("m_out_src2", out_src2, ms2);
            check("m_out_rd", out_rd, mrd);
            check("m_out_rd_wen", out_rd_wen, mwen);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                        input logic [AW-1:0] rd, input logic wen);
      in_valid = 1'b1; in_rs1 = r1; in_rs2 = r2; in_rd = rd; in_rd_wen = wen;
   endtask

   task automatic wb(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      wb_valid = v; wb_addr = a; wb_data = d;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_src1", out_src1, 0);
      check("rst_out_src2", out_src2, 0);
      check("rst_out_rd", out_rd, 0);
      check("rst_out_rd_wen", out_rd_wen, 0);
      check("rst_idle", idle, 1);
      check("rst_in_ready", in_ready, 1);
      chk_en = 1'b1;

      // Basic read
      issue(5, 6, 7, 1);
      step();
      in_valid = 1'b0;
      check("basic_src1", out_src1, 32'h11);
      check("basic_src2", out_src2, 32'h22);
      check("basic_rd", out_rd, 7);
      check("basic_valid", out_valid, 1);
      check("basic_idle", idle, 0);

      // RAW on x7, resolved by same-cycle writeback forwarding
      issue(7, 0, 8, 1);
      #1 check("raw_stall", in_ready, 0);
      step(); step();
      check("raw_stall_held", in_ready, 0);
      wb(1, 7, 32'hABCD);
      #1 check("raw_release", in_ready, 1);
      step();
      in_valid = 1'b0; wb(0, 0, 0);
      check("raw_fwd_src1", out_src1, 32'hABCD);
      check("raw_fwd_rd", out_rd, 8);
      issue(7, 0, 0, 0);
      #1 check("raw_x7_clear", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("raw_rf_src1", out_src1, 32'hABCD);

      // WAW with same-cycle clear: set wins
      issue(0, 0, 3, 1);
      step();
      issue(0, 0, 3, 1);
      wb(1, 3, 32'h33);
      #1 check("waw_ready", in_ready, 1);
      step();
      wb(0, 0, 0);
      issue(3, 0, 0, 0);
      #1 check("waw_still_pending", in_ready, 0);
      wb(1, 3, 32'h44);
      #1 check("waw_release", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("waw_fwd_src1", out_src1, 32'h44);
      wb(1, 8, 32'h88);
      step();
      wb(0, 0, 0);

      // x0 handling
      issue(0, 0, 0, 1);
      wb(1, 0, 32'hFFFF);
      #1 check("x0_ready", in_ready, 1);
      step();
      in_valid = 1'b0; wb(0, 0, 0);
      check("x0_src1", out_src1, 0);
      check("x0_src2", out_src2, 0);
      check("x0_rd_wen", out_rd_wen, 1);
      step();
      check("x0_idle", idle, 1);

      // Backpressure then back-to-back transfer
      out_ready = 1'b0;
      issue(5, 6, 9, 0);
      step();
      issue(6, 5, 10, 0);
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_in_ready", in_ready, 0);
         check("bp_src1_hold", out_src1, 32'h11);
         check("bp_rd_hold", out_rd, 9);
         step();
      end
      out_ready = 1'b1;
      #1 check("bp_release", in_ready, 1);
      step();
      check("b2b_valid", out_valid, 1);
      check("b2b_src1", out_src1, 32'h22);
      check("b2b_src2", out_src2, 32'h11);
      in_valid = 1'b0;

      // Flush with x4 and x9 pending
      issue(0, 0, 4, 1);
      step();
      issue(0, 0, 9, 1);
      step();
      in_valid = 1'b0;
      check("fl_busy", idle, 0);
      flush = 1'b1;
      #1 check("fl_in_ready", in_ready, 0);
      step();
      flush = 1'b0;
      check("fl_idle", idle, 1);
      check("fl_out_valid", out_valid, 0);

      // Reset mid-stream
      issue(0, 0, 4, 1);
      step();
      issue(0, 0, 9, 1);
      step();
      issue(5, 6, 11, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      check("rst2_out_valid", out_valid, 0);
      check("rst2_out_src1", out_src1, 0);
      check("rst2_out_src2", out_src2, 0);
      check("rst2_out_rd", out_rd, 0);
      check("rst2_out_rd_wen", out_rd_wen, 0);
      check("rst2_idle", idle, 1);
      issue(4, 9, 0, 0);
      #1 check("rst2_in_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      step(); step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
